ext_trig_scheduler: RTL
=======================

# ext_trig_scheduler

Sequences the single external trigger output (`ext_trig_out`) of the trigger board. It arbitrates between NREQ coincidence requests, a one-shot software force and a rolling auto-trigger. Each attempt is prescaled, the output pulse is shaped, and deadtime is enforced. No new attempts start while the timing-calibration window (`spareleft`) is open. The block sits in the `clk_adc` domain, downstream of the per-channel trigger recovery logic and upstream of the ext_trig output pin.

## Interface
Parameters:
- NREQ, 4: number of coincidence request inputs (1..6).
- FIRE_TICKS, 4: ext_trig_out pulse width in clk_adc cycles (≥1).
- DEAD_TICKS, 20: cycles from one attempt to the next allowed attempt (> FIRE_TICKS).
- AUTO_BIT, 26: auto-trigger period is 2^AUTO_BIT cycles without an accepted trigger.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk_adc  in  1  clock.
- rst  in  1  reset.
- enable  in  1  0 blocks new attempts; a pulse already in progress completes.
- cal_window  in  1  driven from spareleft; 1 blocks new attempts.
- req  in  NREQ  coincidence request levels.
- req_mask  in  NREQ  1 = request enabled.
- randnum  in  32  per-cycle random value.
- prescale  in  32  a req attempt passes iff randnum <= prescale (unsigned).
- auto_en  in  1  enables the rolling trigger.
- force  in  1  single-cycle software trigger strobe.
- clr_counts  in  1  synchronous clear of both counters.
- ext_trig_out  out  1  trigger pulse, registered.
- src_id  out  3  source of the last attempt: 0..NREQ-1 = req index, 6 = auto, 7 = force.
- trig_count  out  32  accepted triggers; wraps.
- veto_count  out  32  req attempts rejected by prescale; wraps.
- busy  out  1  1 whenever state != IDLE.

## Operation
- FSM states: IDLE, FIRE, DEAD.
- force_pend: set by `force`, cleared when a force attempt is taken. If set and serviced in the same cycle, it stays set.
- auto_cnt: counts up every cycle and clears on every accepted trigger. auto_pend is set when auto_cnt[AUTO_BIT]=1 and auto_en=1. auto_pend clears when an auto attempt is taken; auto_cnt clears at the same time.
- Attempt condition: state IDLE, enable=1, cal_window=0, and any of force_pend, (req & req_mask) != 0, or auto_pend.
- Priority: force > req > auto.
  - Among req, the winner is chosen round-robin: first set bit at index ≥ rr_ptr, cyclic.
  - After any req attempt by index k (accepted or vetoed), rr_ptr becomes (k+1) mod NREQ.
- Accepted attempt:
  - Applies to force, to auto, and to req when randnum <= prescale.
  - Next state is FIRE; src_id is loaded; trig_count increments.
- Vetoed req attempt:
  - Next state is DEAD; veto_count increments; src_id is loaded; ext_trig_out stays 0.
- FIRE: lasts FIRE_TICKS cycles, then DEAD.
- DEAD: returns to IDLE so that the next attempt edge is exactly DEAD_TICKS cycles after the previous attempt edge.
- Request inputs are levels and are not latched. A req that drops before service is lost.
- cal_window or enable going high during FIRE/DEAD does not truncate the pulse or the deadtime.
- clr_counts wins over a simultaneous increment; the counter ends at 0.
- Reset values: state IDLE, ext_trig_out 0, src_id 0, trig_count 0, veto_count 0, busy 0, rr_ptr 0, auto_cnt 0, force_pend 0, auto_pend 0.

## Timing
- Attempt decided at clock edge t.
- ext_trig_out = 1 for edges t+1 .. t+FIRE_TICKS; 0 otherwise.
- Counters and src_id update at edge t+1.
- busy = 1 from edge t+1 through edge t+DEAD_TICKS−1. The next attempt can be taken at edge t+DEAD_TICKS.
- force is recognised on the edge where it is sampled high; the earliest attempt is the following edge.
- Reset is asserted asynchronously and released synchronously to clk_adc by the board-level reset synchroniser.

## Structure
- Package trig_sched_pkg holds:
  - the state enum {IDLE, FIRE, DEAD};
  - constants SRC_AUTO=3'd6 and SRC_FORCE=3'd7;
  - a pass_prescale(randnum, prescale) function.
- One sub-module, rr_arbiter #(N): inputs req vector and pointer; outputs valid and winner index (combinational).
- The pointer register lives in ext_trig_scheduler.

## Test plan
- Setup: NREQ=4, FIRE_TICKS=4, DEAD_TICKS=20, AUTO_BIT=6.
- req=4'b0001, prescale=all-ones, held high: ext_trig_out pulses 4 cycles wide every 20 cycles; trig_count=5 after 100 cycles; veto_count=0.
- req=4'b1010 held, prescale=0, randnum=1: no pulses; src_id alternates 1,3,1,...; veto_count +1 every 20 cycles.
- force pulsed while req=4'b0100 is high: first pulse has src_id=7, trig_count=1; the next attempt 20 cycles later has src_id=2.
- cal_window=1 with req high and force pulsed: no pulse. After cal_window drops, force fires on the next edge (src_id=7). If cal_window rises mid-FIRE, the pulse is still 4 cycles.
- auto_en=1, no req: pulses with src_id=6 once 2^6 cycles have elapsed since the last accepted trigger. A req trigger accepted in between restarts the 64-cycle interval.
- Async rst asserted mid-FIRE: ext_trig_out, busy and both counters are 0 immediately. After release, the first attempt occurs on the first eligible edge.

Source files
------------

// File: rtl/trig_sched_pkg.sv
// Shared types and helpers for the external trigger scheduler.
package trig_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        DEAD
    } state_e;

    localparam logic [2:0] SRC_AUTO  = 3'd6;
    localparam logic [2:0] SRC_FORCE = 3'd7;

    function automatic logic pass_prescale(input logic [31:0] randnum,
                                           input logic [31:0] prescale);
        return randnum <= prescale;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at index >= ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] winner
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (req[idx]) begin
                valid  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/ext_trig_scheduler.sv
// Arbitrates force/req/auto trigger attempts, prescales req attempts, shapes the
// ext_trig pulse and enforces a fixed attempt-to-attempt deadtime.
module ext_trig_scheduler
    import trig_sched_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned FIRE_TICKS = 4,
    parameter int unsigned DEAD_TICKS = 20,
    parameter int unsigned AUTO_BIT   = 26
) (
    input  logic            clk_adc,
    input  logic            rst,
    input  logic            enable,
    input  logic            cal_window,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_mask,
    input  logic [31:0]     randnum,
    input  logic [31:0]     prescale,
    input  logic            auto_en,
    input  logic            force_trig,
    input  logic            clr_counts,
    output logic            ext_trig_out,
    output logic [2:0]      src_id,
    output logic [31:0]     trig_count,
    output logic [31:0]     veto_count,
    output logic            busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(DEAD_TICKS + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   tick_q, tick_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AUTO_BIT:0] auto_cnt_q, auto_cnt_d;
    logic            force_pend_q, force_pend_d;
    logic            auto_pend_q, auto_pend_d;
    logic            trig_q, trig_d;
    logic [2:0]      src_q, src_d;
    logic [31:0]     trig_cnt_q, trig_cnt_d;
    logic [31:0]     veto_cnt_q, veto_cnt_d;

    logic            req_valid;
    logic [PW-1:0]   req_idx;
    logic            can_attempt, take_force, take_req, take_auto;
    logic            req_pass, accept, veto;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req    (req & req_mask),
        .ptr    (rr_ptr_q),
        .valid  (req_valid),
        .winner (req_idx)
    );

    always_comb begin
        can_attempt = (state_q == IDLE) && enable && !cal_window;
        take_force  = can_attempt && force_pend_q;
        take_req    = can_attempt && !force_pend_q && req_valid;
        take_auto   = can_attempt && !force_pend_q && !req_valid && auto_pend_q;
        req_pass    = pass_prescale(randnum, prescale);
        accept      = take_force || take_auto || (take_req && req_pass);
        veto        = take_req && !req_pass;
    end

    // tick counts cycles since the attempt edge; it drives both FIRE and DEAD exits.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FIRE;
                    tick_d  = CW'(1);
                end else if (veto) begin
                    state_d = DEAD;
                    tick_d  = CW'(1);
                end
            end
            FIRE: begin
                tick_d = tick_q + CW'(1);
                if (tick_q == CW'(FIRE_TICKS)) begin
                    state_d = DEAD;
                end
            end
            DEAD: begin
                tick_d = tick_q + CW'(1);
                if (tick_q >= CW'(DEAD_TICKS - 1)) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase
    end

    always_comb begin
        trig_d       = (state_d == FIRE);
        src_d        = src_q;
        rr_ptr_d     = rr_ptr_q;
        force_pend_d = force_trig || (force_pend_q && !take_force);
        auto_cnt_d   = accept ? '0 : auto_cnt_q + 1'b1;
        auto_pend_d  = take_auto ? 1'b0 : (auto_pend_q || (auto_cnt_q[AUTO_BIT] && auto_en));
        trig_cnt_d   = trig_cnt_q;
        veto_cnt_d   = veto_cnt_q;
        if (take_force) begin
            src_d = SRC_FORCE;
        end else if (take_req) begin
            src_d    = 3'(req_idx);
            rr_ptr_d = (req_idx == PW'(NREQ - 1)) ? '0 : req_idx + 1'b1;
        end else if (take_auto) begin
            src_d = SRC_AUTO;
        end
        if (clr_counts) begin
            trig_cnt_d = '0;
            veto_cnt_d = '0;
        end else begin
            if (accept) trig_cnt_d = trig_cnt_q + 32'd1;
            if (veto)   veto_cnt_d = veto_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            rr_ptr_q     <= '0;
            auto_cnt_q   <= '0;
            force_pend_q <= 1'b0;
            auto_pend_q  <= 1'b0;
            trig_q       <= 1'b0;
            src_q        <= '0;
            trig_cnt_q   <= '0;
            veto_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            rr_ptr_q     <= rr_ptr_d;
            auto_cnt_q   <= auto_cnt_d;
            force_pend_q <= force_pend_d;
            auto_pend_q  <= auto_pend_d;
            trig_q       <= trig_d;
            src_q        <= src_d;
            trig_cnt_q   <= trig_cnt_d;
            veto_cnt_q   <= veto_cnt_d;
        end
    end

    assign ext_trig_out = trig_q;
    assign src_id       = src_q;
    assign trig_count   = trig_cnt_q;
    assign veto_count   = veto_cnt_q;
    assign busy         = (state_q != IDLE);

endmodule
